// File: rtl/seven_seg_scan_driver_if.sv
// Load port bundle for seven_seg_scan_driver.
//   load_valid : source has a 32-bit value on load_data this cycle
//   load_ready : driver's pending buffer is empty and will take the value
//   load_data  : eight hex nibbles, nibble k is shown on digit k
// master = value source, slave = display driver.
`timescale 1ns/1ps
interface seven_seg_scan_driver_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for an 8-digit seven-segment display.
// A 32-bit value is taken over the load interface into a pending buffer and
// moved into the display register in IDLE or at the end of a scan frame, so a
// new value never tears mid-frame. One digit is lit at a time, each held for
// CLK_DIV clocks.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : 1 = scan, 0 = display dark
//   load        : valid/ready value port (slave side)
//   dp_mask     : live decimal-point mask, bit k = digit k
//   anodes      : one-hot active-high digit select (registered)
//   segments    : {a,b,c,d,e,f,g,dp} active-high (registered)
//   digit_idx   : digit currently being scanned
//   frame_done  : high during the last cycle of digit 7
// Optional build macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks segments a..g
// on digits above the most significant nonzero nibble (digit 0 never blanks).
`timescale 1ns/1ps
module seven_seg_scan_driver #(
  parameter int CLK_DIV = 100000,
  parameter int CNT_W   = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  seven_seg_scan_driver_if.slave  load,
  input  logic [7:0]              dp_mask,
  output logic [7:0]              anodes,
  output logic [7:0]              segments,
  output logic [2:0]              digit_idx,
  output logic                    frame_done
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] prescale_reg, prescale_next;
  logic [2:0]       digit_reg, digit_next;
  logic [31:0]      display_reg, pending_reg;
  logic             pending_full_reg;
  logic [7:0]       anodes_reg, anodes_next;
  logic [7:0]       segments_reg, segments_next;
  logic             terminal, wrap, commit, accept, blank;
  logic [3:0]       nibble;
  logic [6:0]       glyph;

  assign terminal = (prescale_reg == CNT_W'(CLK_DIV - 1));
  // Frame end: last cycle of digit 7 while still enabled; an enable drop on
  // that same cycle wins and no frame is reported.
  assign wrap     = (state_reg == SCAN) && enable && terminal && (digit_reg == 3'd7);
  assign commit   = pending_full_reg && ((state_reg == IDLE) || wrap);
  // Commit and accept are mutually exclusive: commit needs a full buffer,
  // accept needs an empty one.
  assign accept   = load.load_valid && !pending_full_reg;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      prescale_reg     <= '0;
      digit_reg        <= 3'd0;
      display_reg      <= 32'd0;
      pending_reg      <= 32'd0;
      pending_full_reg <= 1'b0;
      anodes_reg       <= 8'd0;
      segments_reg     <= 8'd0;
    end else begin
      state_reg    <= state_next;
      prescale_reg <= prescale_next;
      digit_reg    <= digit_next;
      anodes_reg   <= anodes_next;
      segments_reg <= segments_next;
      if (commit) begin
        display_reg      <= pending_reg;
        pending_full_reg <= 1'b0;
      end
      if (accept) begin
        pending_reg      <= load.load_data;
        pending_full_reg <= 1'b1;
      end
    end
  end

  // Next state and scan position
  always_comb begin
    state_next    = state_reg;
    prescale_next = '0;
    digit_next    = 3'd0;
    case (state_reg)
      IDLE: if (enable) state_next = SCAN;
      SCAN: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (terminal) begin
          digit_next = digit_reg + 3'd1;
        end else begin
          prescale_next = prescale_reg + 1'b1;
          digit_next    = digit_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [7:0] nz;
  logic [2:0] top_digit;
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nz
      assign nz[gi] = |display_reg[4*gi +: 4];
    end
  endgenerate
  always_comb begin
    top_digit = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (nz[k]) top_digit = 3'(k);
    end
  end
  assign blank = (digit_reg > top_digit);
`else
  assign blank = 1'b0;
`endif

  assign nibble = display_reg[{digit_reg, 2'b00} +: 4];

  // Outputs: next values of the registered display pins, plus frame_done
  always_comb begin
    case (nibble)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1111011;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b1001110;
      4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;
      default: glyph = 7'b1000111;
    endcase
    anodes_next   = 8'd0;
    segments_next = 8'd0;
    if (state_reg == SCAN) begin
      anodes_next   = 8'd1 << digit_reg;
      segments_next = {(blank ? 7'd0 : glyph), dp_mask[digit_reg]};
    end
    frame_done = wrap;
  end

  assign anodes          = anodes_reg;
  assign segments        = segments_reg;
  assign digit_idx       = digit_reg;
  assign load.load_ready = !pending_full_reg;

endmodule
